output_link_tx: RTL and testbench
=================================

# output_link_tx

Transmit end of a router output link: registers the flit granted through the crossbar onto the link toward the downstream router's input port. It tracks the downstream per-VC on/off and allocatable status and keeps a per-VC ownership state machine. From these it tells the VC allocator which downstream VCs are free and tells the switch allocator which VCs may send. It sits between the crossbar output and the physical link, one instance per output port, and is the counterpart of the downstream input port's receive, buffering and on/off logic.

## Interface
Parameters:
- VC_NUM, default VC_NUM (noc_params): number of virtual channels on the link.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- xb_flit_i  input  flit_t  flit from the crossbar; uses fields flit_label (HEAD/BODY/TAIL/HEADTAIL) and vc_id.
- xb_valid_i  input  1  xb_flit_i is valid this cycle.
- va_grant_i  input  [VC_NUM-1:0]  VC allocator reserved downstream VC v for some input packet.
- on_off_i  input  [VC_NUM-1:0]  downstream buffer of VC v can accept a flit (high = on).
- vc_allocatable_i  input  [VC_NUM-1:0]  downstream VC v has drained its previous packet.
- data_o  output  flit_t  flit driven on the link.
- valid_flit_o  output  1  data_o is valid.
- vc_free_o  output  [VC_NUM-1:0]  downstream VC v may be granted by the VC allocator.
- sa_ready_o  output  [VC_NUM-1:0]  a flit on VC v may be switched this cycle.
- error_o  output  [VC_NUM-1:0]  sticky protocol-violation flag per VC.

## Operation
Per-VC state machine, states IDLE, RESERVED, ACTIVE.
- IDLE -> RESERVED when va_grant_i[v] is high.
- RESERVED -> ACTIVE when an accepted HEAD flit has vc_id == v.
- RESERVED -> IDLE when an accepted HEADTAIL flit has vc_id == v.
- ACTIVE -> ACTIVE on an accepted BODY flit for v.
- ACTIVE -> IDLE on an accepted TAIL flit for v.
- "Accepted" means xb_valid_i is high at the clock edge; the VC is xb_flit_i.vc_id.

Outputs:
- vc_free_o[v] = (state[v]==IDLE) & vc_allocatable_i[v]; combinational.
- sa_ready_o[v] = on_off_i[v] & (state[v]==RESERVED | state[v]==ACTIVE); combinational.

Errors (error_o[v] is set and held until rst; the flit is still forwarded and the state transition is still taken where one is defined):
- va_grant_i[v] while state[v] != IDLE. The state is unchanged by the grant.
- An accepted flit for v while state[v]==IDLE. The state stays IDLE.
- An accepted HEAD or HEADTAIL for v in ACTIVE. The state stays ACTIVE.
- An accepted BODY or TAIL for v in RESERVED. The state stays RESERVED.
- An accepted flit for v while on_off_i[v] is low.
- An accepted flit with vc_id >= VC_NUM sets no error bit and changes no state. It is still forwarded.

Simultaneous events:
- A grant and a flit on different VCs are processed independently in the same cycle.
- Multi-hot va_grant_i: each bit is handled independently.
- A grant and a flit on the same VC in the same cycle:
  - The flit rule decides the state transition.
  - The grant is evaluated against the pre-edge state.
  - A grant on the same VC as a TAIL is therefore an error. The VC ends IDLE, and error_o[v] is set.

## Timing
- Reset values:
  - data_o = '0, valid_flit_o = 0, error_o = '0, all states IDLE.
  - Consequently vc_free_o = vc_allocatable_i and sa_ready_o = '0.
- Link latency: xb_flit_i/xb_valid_i at edge N appear on data_o/valid_flit_o after edge N. This is exactly one cycle, with no bubbles and no backpressure.
- When xb_valid_i is low, valid_flit_o goes low next cycle. data_o holds its last value.
- State, and therefore vc_free_o/sa_ready_o, reflects a grant or flit from the cycle after the edge on which it was sampled.
- on_off_i and vc_allocatable_i are used combinationally and are not registered here.
- rst asserted mid-packet clears all state and the output register asynchronously. Any in-flight packet is abandoned with no error flagged.

## Test plan
- Reset: assert rst with traffic pending -> data_o=0, valid_flit_o=0, error_o=0, vc_free_o equals vc_allocatable_i, sa_ready_o=0.
- Full packet on VC1:
  - Stimulus: grant va_grant_i=4'b0010; next cycle send HEAD, BODY, BODY, TAIL back-to-back with on_off_i=all ones.
  - Required: valid_flit_o high for 4 cycles, each flit one cycle late. sa_ready_o[1] is high from the grant+1 cycle through the TAIL cycle. vc_free_o[1] returns high the cycle after the TAIL is accepted. error_o=0.
- HEADTAIL on VC0 after grant -> VC0 goes RESERVED -> IDLE, one flit on the link, no error.
- Off violation: VC2 ACTIVE with on_off_i[2]=0, send BODY on VC2 -> flit is forwarded and error_o[2]=1 persists until rst.
- Illegal sequences:
  - BODY on an IDLE VC3 -> error_o[3]=1, VC3 stays IDLE.
  - Double grant on VC1 -> error_o[1]=1.
- Concurrency: grant VC0 while sending the TAIL of VC1 in the same cycle -> VC0 RESERVED, VC1 IDLE, no errors.

Source files
------------

// File: rtl/output_link_tx.sv
// -----------------------------------------------------------------------------
// output_link_tx
//
// Transmit end of one router output link. The flit granted through the crossbar
// is registered onto the link (one cycle, no bubbles, no backpressure). A small
// ownership state machine per downstream VC (IDLE / RESERVED / ACTIVE) follows
// VC-allocator grants and the HEAD/BODY/TAIL flits sent on the link. From it the
// block tells the VC allocator which downstream VCs are free and the switch
// allocator which VCs may send. Protocol violations raise a sticky per-VC flag.
//
// Ports
//   clk               rising-edge clock
//   rst               asynchronous active-high reset
//   xb_flit_i         flit from the crossbar (flit_label, vc_id, data)
//   xb_valid_i        xb_flit_i valid this cycle
//   va_grant_i        per-VC reservation by the VC allocator
//   on_off_i          per-VC downstream buffer on/off (high = can accept)
//   vc_allocatable_i  per-VC downstream VC has drained its previous packet
//   data_o            flit on the link (holds last value when idle)
//   valid_flit_o      data_o valid
//   vc_free_o         VC may be granted by the VC allocator
//   sa_ready_o        a flit on that VC may be switched this cycle
//   error_o           sticky per-VC protocol-violation flag
// -----------------------------------------------------------------------------

package noc_params;
    localparam int VC_NUM  = 4;
    // One spare bit so out-of-range VC ids can be represented on the link.
    localparam int VC_ID_W = 3;
    localparam int DATA_W  = 16;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t          flit_label;
        logic [VC_ID_W-1:0]   vc_id;
        logic [DATA_W-1:0]    data;
    } flit_t;
endpackage

module output_link_tx #(
    parameter int VC_NUM = noc_params::VC_NUM
) (
    input  logic                 clk,
    input  logic                 rst,
    input  noc_params::flit_t    xb_flit_i,
    input  logic                 xb_valid_i,
    input  logic [VC_NUM-1:0]    va_grant_i,
    input  logic [VC_NUM-1:0]    on_off_i,
    input  logic [VC_NUM-1:0]    vc_allocatable_i,
    output noc_params::flit_t    data_o,
    output logic                 valid_flit_o,
    output logic [VC_NUM-1:0]    vc_free_o,
    output logic [VC_NUM-1:0]    sa_ready_o,
    output logic [VC_NUM-1:0]    error_o
);

    localparam int ID_W = noc_params::VC_ID_W;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RESERVED = 2'd1,
        ST_ACTIVE   = 2'd2
    } vc_state_e;

    vc_state_e          state_q [VC_NUM];
    vc_state_e          state_d [VC_NUM];
    logic [VC_NUM-1:0]  error_q;
    logic [VC_NUM-1:0]  error_d;
    noc_params::flit_t  data_q;
    logic               valid_q;

    logic               is_head_s;
    logic               is_tail_s;
    logic [VC_NUM-1:0]  flit_hit_s;

    // Classify the incoming flit: HEADTAIL both opens and closes a packet.
    always_comb begin
        is_head_s = 1'b0;
        is_tail_s = 1'b0;
        case (xb_flit_i.flit_label)
            noc_params::HEAD: begin
                is_head_s = 1'b1;
                is_tail_s = 1'b0;
            end
            noc_params::BODY: begin
                is_head_s = 1'b0;
                is_tail_s = 1'b0;
            end
            noc_params::TAIL: begin
                is_head_s = 1'b0;
                is_tail_s = 1'b1;
            end
            noc_params::HEADTAIL: begin
                is_head_s = 1'b1;
                is_tail_s = 1'b1;
            end
            default: begin
                is_head_s = 1'b0;
                is_tail_s = 1'b0;
            end
        endcase
    end

    // Per-VC accepted-flit decode; an out-of-range vc_id matches no VC.
    always_comb begin
        flit_hit_s = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            flit_hit_s[v] = xb_valid_i && (xb_flit_i.vc_id == ID_W'(v));
        end
    end

    // Per-VC next state and sticky error. The grant is judged against the
    // pre-edge state; when a flit for the same VC arrives, the flit rule alone
    // decides where the VC goes.
    always_comb begin
        for (int v = 0; v < VC_NUM; v++) begin
            logic grant_err;
            logic off_err;
            logic seq_err;

            state_d[v] = state_q[v];
            seq_err    = 1'b0;
            grant_err  = va_grant_i[v] && (state_q[v] != ST_IDLE);
            off_err    = flit_hit_s[v] && !on_off_i[v];

            if (flit_hit_s[v]) begin
                case (state_q[v])
                    ST_IDLE: begin
                        // Flit without a reservation: flagged, VC stays idle.
                        seq_err    = 1'b1;
                        state_d[v] = ST_IDLE;
                    end
                    ST_RESERVED: begin
                        if (is_head_s) begin
                            state_d[v] = is_tail_s ? ST_IDLE : ST_ACTIVE;
                        end else begin
                            seq_err    = 1'b1;
                            state_d[v] = ST_RESERVED;
                        end
                    end
                    ST_ACTIVE: begin
                        if (is_head_s) begin
                            seq_err    = 1'b1;
                            state_d[v] = ST_ACTIVE;
                        end else if (is_tail_s) begin
                            state_d[v] = ST_IDLE;
                        end else begin
                            state_d[v] = ST_ACTIVE;
                        end
                    end
                    default: begin
                        // Corrupted encoding: return to a safe state and flag it.
                        seq_err    = 1'b1;
                        state_d[v] = ST_IDLE;
                    end
                endcase
            end else if (va_grant_i[v] && (state_q[v] == ST_IDLE)) begin
                state_d[v] = ST_RESERVED;
            end else begin
                state_d[v] = state_q[v];
            end

            error_d[v] = error_q[v] | grant_err | off_err | seq_err;
        end
    end

    // VC ownership state and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v] <= ST_IDLE;
            end
            error_q <= '0;
        end else begin
            for (int v = 0; v < VC_NUM; v++) begin
                state_q[v] <= state_d[v];
            end
            error_q <= error_d;
        end
    end

    // Link output register: data holds its last value when no flit is sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (xb_valid_i) begin
                data_q <= xb_flit_i;
            end else begin
                data_q <= data_q;
            end
            valid_q <= xb_valid_i;
        end
    end

    // Allocator status: downstream on/off and allocatable are used live.
    always_comb begin
        vc_free_o  = '0;
        sa_ready_o = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            vc_free_o[v]  = (state_q[v] == ST_IDLE) && vc_allocatable_i[v];
            sa_ready_o[v] = on_off_i[v] &&
                            ((state_q[v] == ST_RESERVED) || (state_q[v] == ST_ACTIVE));
        end
    end

    assign data_o       = data_q;
    assign valid_flit_o = valid_q;
    assign error_o      = error_q;

endmodule

// File: tb/tb_output_link_tx.sv
module tb_output_link_tx;
    import noc_params::*;

    localparam int NV = noc_params::VC_NUM;

    logic            clk = 1'b0;
    logic            rst;
    flit_t           xb_flit;
    logic            xb_valid;
    logic [NV-1:0]   va_grant;
    logic [NV-1:0]   on_off;
    logic [NV-1:0]   vc_alloc;
    flit_t           data_o;
    logic            valid_o;
    logic [NV-1:0]   vc_free;
    logic [NV-1:0]   sa_ready;
    logic [NV-1:0]   err;

    int errors = 0;
    int checks = 0;

    // Reference model: a VC is "owned" from grant until its packet closes,
    // "open" once the packet's head has gone out.
    bit    m_owned [NV];
    bit    m_open  [NV];
    bit    m_err   [NV];
    flit_t m_data;
    bit    m_valid;

    output_link_tx #(.VC_NUM(NV)) dut (
        .clk              (clk),
        .rst              (rst),
        .xb_flit_i        (xb_flit),
        .xb_valid_i       (xb_valid),
        .va_grant_i       (va_grant),
        .on_off_i         (on_off),
        .vc_allocatable_i (vc_alloc),
        .data_o           (data_o),
        .valid_flit_o     (valid_o),
        .vc_free_o        (vc_free),
        .sa_ready_o       (sa_ready),
        .error_o          (err)
    );

    always #5 clk = ~clk;

    function automatic logic [NV-1:0] m_free();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = !m_owned[v] && vc_alloc[v];
        return r;
    endfunction

    function automatic logic [NV-1:0] m_ready();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = m_owned[v] && on_off[v];
        return r;
    endfunction

    function automatic logic [NV-1:0] m_errv();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = m_err[v];
        return r;
    endfunction

    task automatic model_clear();
        for (int v = 0; v < NV; v++) begin
            m_owned[v] = 1'b0;
            m_open[v]  = 1'b0;
            m_err[v]   = 1'b0;
        end
        m_data  = '0;
        m_valid = 1'b0;
    endtask

    // Advance the model with the inputs present now, then clock the DUT.
    task automatic tick();
        bit hit, is_head, is_tail;
        is_head = (xb_flit.flit_label == HEAD) || (xb_flit.flit_label == HEADTAIL);
        is_tail = (xb_flit.flit_label == TAIL) || (xb_flit.flit_label == HEADTAIL);
        if (xb_valid) m_data = xb_flit;
        m_valid = xb_valid;
        for (int v = 0; v < NV; v++) begin
            hit = xb_valid && (int'(xb_flit.vc_id) == v);
            if (va_grant[v] && m_owned[v]) m_err[v] = 1'b1;
            if (hit) begin
                if (!on_off[v]) m_err[v] = 1'b1;
                if (!m_owned[v]) m_err[v] = 1'b1;
                else if (is_head == m_open[v]) m_err[v] = 1'b1;
                else begin
                    if (is_head) m_open[v] = 1'b1;
                    if (is_tail) begin
                        m_owned[v] = 1'b0;
                        m_open[v]  = 1'b0;
                    end
                end
            end else if (va_grant[v]) begin
                m_owned[v] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        xb_valid = 1'b0;
        va_grant = '0;
    endtask

    task automatic send(input flit_label_t lbl, input int vc);
        xb_flit.flit_label = lbl;
        xb_flit.vc_id      = 3'(vc);
        xb_flit.data       = 16'($urandom);
        xb_valid           = 1'b1;
    endtask

    task automatic do_reset();
        drive_idle();
        on_off   = '1;
        vc_alloc = '1;
        rst      = 1'b1;
        model_clear();
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        va_grant = 4'b0001;
        tick();
        va_grant = 4'b0000;
        send(HEAD, 0);
        tick();
        checks++;
        if (valid_o !== 1'b1 || sa_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre valid=%b sa_ready=%b need valid=1 sa_ready[0]=1", valid_o, sa_ready);
        end
        send(BODY, 0);
        va_grant = 4'b0110;
        vc_alloc = 4'b1011;
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        checks++;
        if (data_o !== flit_t'(0) || valid_o !== 1'b0 || err !== 4'b0000) begin
            errors++;
            $display("FAIL rst_out data=%h valid=%b err=%b need 0/0/0", data_o, valid_o, err);
        end
        checks++;
        if (vc_free !== 4'b1011 || sa_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rst_alloc vc_free=%b sa_ready=%b need 1011/0000", vc_free, sa_ready);
        end
        drive_idle();
        #2;
        rst = 1'b0;
        vc_alloc = '1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_packet();
        flit_label_t lbls [4] = '{HEAD, BODY, BODY, TAIL};
        do_reset();
        va_grant = 4'b0010;
        tick();
        va_grant = 4'b0000;
        checks++;
        if (sa_ready[1] !== 1'b1 || vc_free[1] !== 1'b0) begin
            errors++;
            $display("FAIL fp_grant sa_ready=%b vc_free=%b need sa_ready[1]=1 vc_free[1]=0", sa_ready, vc_free);
        end
        for (int k = 0; k < 4; k++) begin
            send(lbls[k], 1);
            tick();
            checks++;
            if (valid_o !== 1'b1 || data_o !== m_data) begin
                errors++;
                $display("FAIL fp_link k=%0d valid=%b data=%h need 1/%h", k, valid_o, data_o, m_data);
            end
            checks++;
            if (sa_ready[1] !== (k != 3) || vc_free[1] !== (k == 3)) begin
                errors++;
                $display("FAIL fp_status k=%0d sa_ready=%b vc_free=%b", k, sa_ready, vc_free);
            end
        end
        drive_idle();
        tick();
        checks++;
        if (valid_o !== 1'b0 || data_o !== m_data || err !== 4'b0000) begin
            errors++;
            $display("FAIL fp_after valid=%b data=%h err=%b need 0/%h/0000", valid_o, data_o, err, m_data);
        end
    endtask

    task automatic test_headtail();
        do_reset();
        va_grant = 4'b0001;
        tick();
        va_grant = 4'b0000;
        send(HEADTAIL, 0);
        tick();
        checks++;
        if (valid_o !== 1'b1 || data_o !== m_data || vc_free[0] !== 1'b1 || sa_ready[0] !== 1'b0 || err !== 4'b0000) begin
            errors++;
            $display("FAIL ht valid=%b data=%h vc_free=%b sa_ready=%b err=%b", valid_o, data_o, vc_free, sa_ready, err);
        end
        drive_idle();
        tick();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL ht_one_flit valid=%b need 0", valid_o);
        end
    endtask

    task automatic test_off_violation();
        do_reset();
        va_grant = 4'b0100;
        tick();
        va_grant = 4'b0000;
        send(HEAD, 2);
        tick();
        on_off = 4'b1011;
        send(BODY, 2);
        tick();
        checks++;
        if (valid_o !== 1'b1 || data_o !== m_data || err !== 4'b0100 || sa_ready[2] !== 1'b0) begin
            errors++;
            $display("FAIL off_body valid=%b data=%h err=%b sa_ready=%b need err=0100", valid_o, data_o, err, sa_ready);
        end
        on_off = 4'b1111;
        send(TAIL, 2);
        tick();
        drive_idle();
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (err !== 4'b0100 || vc_free[2] !== 1'b1) begin
            errors++;
            $display("FAIL off_sticky err=%b vc_free=%b need err=0100 vc_free[2]=1", err, vc_free);
        end
        do_reset();
        checks++;
        if (err !== 4'b0000) begin
            errors++;
            $display("FAIL off_clear err=%b need 0000", err);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        send(BODY, 3);
        tick();
        checks++;
        if (err !== 4'b1000 || vc_free[3] !== 1'b1 || sa_ready[3] !== 1'b0 || valid_o !== 1'b1) begin
            errors++;
            $display("FAIL ill_idle err=%b vc_free=%b sa_ready=%b valid=%b", err, vc_free, sa_ready, valid_o);
        end
        drive_idle();
        va_grant = 4'b0010;
        tick();
        tick();
        va_grant = 4'b0000;
        checks++;
        if (err !== 4'b1010 || sa_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL ill_dgrant err=%b sa_ready=%b need err=1010 sa_ready[1]=1", err, sa_ready);
        end
        send(HEAD, 5);
        tick();
        checks++;
        if (valid_o !== 1'b1 || data_o !== m_data || err !== 4'b1010 || sa_ready !== 4'b0010) begin
            errors++;
            $display("FAIL ill_range valid=%b data=%h err=%b sa_ready=%b", valid_o, data_o, err, sa_ready);
        end
        drive_idle();
    endtask

    task automatic test_concurrency();
        do_reset();
        va_grant = 4'b0010;
        tick();
        va_grant = 4'b0000;
        send(HEAD, 1);
        tick();
        send(TAIL, 1);
        va_grant = 4'b0001;
        tick();
        checks++;
        if (sa_ready !== 4'b0001 || vc_free !== 4'b1110 || err !== 4'b0000) begin
            errors++;
            $display("FAIL cc_diff sa_ready=%b vc_free=%b err=%b need 0001/1110/0000", sa_ready, vc_free, err);
        end
        va_grant = 4'b0000;
        send(HEAD, 0);
        tick();
        send(TAIL, 0);
        va_grant = 4'b0001;
        tick();
        checks++;
        if (err !== 4'b0001 || vc_free[0] !== 1'b1 || sa_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL cc_same err=%b vc_free=%b sa_ready=%b need err=0001 VC0 idle", err, vc_free, sa_ready);
        end
        drive_idle();
    endtask

    task automatic test_random();
        int v;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc % 100 == 99) do_reset();
            drive_idle();
            vc_alloc = 4'($urandom);
            for (int b = 0; b < NV; b++) on_off[b] = ($urandom_range(0, 7) != 0);
            for (int b = 0; b < NV; b++)
                if (!m_owned[b] && $urandom_range(0, 3) == 0) va_grant[b] = 1'b1;
            v = $urandom_range(0, NV - 1);
            if ($urandom_range(0, 15) == 0) begin
                send(flit_label_t'($urandom_range(0, 3)), $urandom_range(0, 5));
                va_grant = 4'($urandom);
            end else if (m_owned[v] && !va_grant[v] && $urandom_range(0, 1) == 1) begin
                on_off[v] = 1'b1;
                if (!m_open[v]) send($urandom_range(0, 1) ? HEAD : HEADTAIL, v);
                else send($urandom_range(0, 2) != 0 ? BODY : TAIL, v);
            end
            tick();
            checks++;
            if (valid_o !== m_valid || data_o !== m_data) begin
                errors++;
                $display("FAIL rnd_link cyc=%0d valid=%b data=%h need %b/%h", cyc, valid_o, data_o, m_valid, m_data);
            end
            checks++;
            if (vc_free !== m_free() || sa_ready !== m_ready() || err !== m_errv()) begin
                errors++;
                $display("FAIL rnd_status cyc=%0d free=%b ready=%b err=%b need %b/%b/%b",
                         cyc, vc_free, sa_ready, err, m_free(), m_ready(), m_errv());
            end
        end
        drive_idle();
    endtask

    initial begin
        rst      = 1'b1;
        xb_flit  = '0;
        xb_valid = 1'b0;
        va_grant = '0;
        on_off   = '1;
        vc_alloc = '1;
        model_clear();
        #12;
        test_reset();
        test_full_packet();
        test_headtail();
        test_off_violation();
        test_illegal();
        test_concurrency();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
